// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and default vectors for the PC sequencer
package pc_seq_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_t;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0040_0100;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: next-PC selection and misaligned-target detection
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        branch_flag,
    input  logic        jalr,
    output logic [31:0] next_pc,
    output logic        misalign
);
    logic [31:0] target;
    // taken target (jalr clears bit0), fall-through otherwise; only taken targets can trap
    always_comb begin
        target   = jalr ? ((rs1 + imm) & ~32'd1) : pc + imm;
        next_pc  = branch_flag ? target : pc + 32'd4;
        misalign = branch_flag & target[1];
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute PC sequencer with misaligned-target trap and retire counter
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Branch_Flag_i,
    input  logic        Jalr_i,
    input  logic [31:0] Imm_i,
    input  logic [31:0] Rs1_i,
    input  logic        Stall_i,
    input  logic        Imem_Ready_i,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus4_o,
    output logic        Fetch_Req_o,
    output logic        Instr_Valid_o,
    output logic        Misalign_o,
    output logic [31:0] Instret_o
);
    state_t      state;
    logic [31:0] next_pc;
    logic        trap;

    assign PC_Plus4_o = PC_o + 32'd4;

    next_pc_calc u_next_pc (
        .pc          (PC_o),
        .imm         (Imm_i),
        .rs1         (Rs1_i),
        .branch_flag (Branch_Flag_i),
        .jalr        (Jalr_i),
        .next_pc     (next_pc),
        .misalign    (trap)
    );

    // state machine; strobes are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            PC_o          <= RESET_VECTOR;
            Instret_o     <= '0;
            Fetch_Req_o   <= 1'b0;
            Instr_Valid_o <= 1'b0;
            Misalign_o    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= FETCH;
                    Fetch_Req_o <= 1'b1;
                end
                FETCH: if (Imem_Ready_i) begin
                    state         <= EXEC;
                    Fetch_Req_o   <= 1'b0;
                    Instr_Valid_o <= 1'b1;
                end
                EXEC: if (!Stall_i) begin
                    Instr_Valid_o <= 1'b0;
                    if (trap) begin
                        state      <= TRAP;
                        Misalign_o <= 1'b1;
                    end else begin
                        state       <= FETCH;
                        Fetch_Req_o <= 1'b1;
                        PC_o        <= next_pc;
                        Instret_o   <= Instret_o + 32'd1;
                    end
                end
                TRAP: begin
                    state       <= FETCH;
                    Misalign_o  <= 1'b0;
                    Fetch_Req_o <= 1'b1;
                    PC_o        <= TRAP_VECTOR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table-driven check of the PC sequencer
module tb_pc_sequencer;
    logic        clk;
    logic        reset_n;
    logic        br, jalr, stall, ready;
    logic [31:0] imm, rs1;
    logic [31:0] pc, pc4, instret;
    logic        fetch_req, valid, mis;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        br;
        logic        jalr;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        logic [31:0] exp_instret;
        logic        exp_trap;
    } vec_t;
    vec_t vecs[9];

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset_n),
        .Branch_Flag_i (br),
        .Jalr_i        (jalr),
        .Imm_i         (imm),
        .Rs1_i         (rs1),
        .Stall_i       (stall),
        .Imem_Ready_i  (ready),
        .PC_o          (pc),
        .PC_Plus4_o    (pc4),
        .Fetch_Req_o   (fetch_req),
        .Instr_Valid_o (valid),
        .Misalign_o    (mis),
        .Instret_o     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_exec();
        int i = 0;
        while (!valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("exec_reached", {31'd0, valid}, 32'd1);
    endtask

    task automatic drive(input logic b, input logic j, input logic [31:0] im, input logic [31:0] r);
        br = b; jalr = j; imm = im; rs1 = r;
    endtask

    initial begin
        logic [31:0] prev_pc;
        vecs[0] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0040_0010, 32'd4,  1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,       32'h0040_0008, 32'd5,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd4,        32'h0040_0021, 32'h0040_0024, 32'd6,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'd6,        32'h0,        32'h0040_0100, 32'd6,  1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h10,       32'h1234_5678, 32'h0040_0104, 32'd7,  1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h0,        32'h0040_0003, 32'h0040_0100, 32'd7,  1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd8,  1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0000, 32'd9,  1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h100,      32'h0,        32'h0000_0100, 32'd10, 1'b0};

        reset_n = 1'b0; stall = 1'b0; ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_pc4", pc4, 32'h0040_0004);
        chk("rst_instret", instret, 32'd0);
        chk("rst_strobes", {29'd0, fetch_req, valid, mis}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("boot_strobes", {29'd0, fetch_req, valid, mis}, 32'd0);
        @(negedge clk);
        chk("first_fetch", {29'd0, fetch_req, valid, mis}, 32'd4);

        for (int k = 0; k < 3; k++) begin
            wait_exec();
            chk("seq_pc", pc, 32'h0040_0000 + 32'(4 * k));
            @(negedge clk);
            chk("seq_instret", instret, 32'(k + 1));
            chk("seq_fetch", {31'd0, fetch_req}, 32'd1);
        end

        prev_pc = 32'h0040_000C;
        for (int v = 0; v < 9; v++) begin
            wait_exec();
            chk("vec_exec_pc", pc, prev_pc);
            drive(vecs[v].br, vecs[v].jalr, vecs[v].imm, vecs[v].rs1);
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (vecs[v].exp_trap) begin
                chk("trap_strobes", {29'd0, fetch_req, valid, mis}, 32'd1);
                chk("trap_pc_hold", pc, prev_pc);
                @(negedge clk);
            end
            chk("vec_strobes", {29'd0, fetch_req, valid, mis}, 32'd4);
            chk("vec_pc", pc, vecs[v].exp_pc);
            chk("vec_instret", instret, vecs[v].exp_instret);
            prev_pc = vecs[v].exp_pc;
        end

        wait_exec();
        for (int c = 0; c < 3; c++) begin
            drive(c[0] ? 1'b0 : 1'b1, 1'b0, 32'h40, 32'h0);
            stall = 1'b1;
            @(negedge clk);
            chk("stall_pc", pc, 32'h0000_0100);
            chk("stall_instret", instret, 32'd10);
            chk("stall_valid", {31'd0, valid}, 32'd1);
        end
        stall = 1'b0;
        drive(1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("release_pc", pc, 32'h0000_0104);
        chk("release_instret", instret, 32'd11);

        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("wait_fetch", {29'd0, fetch_req, valid, mis}, 32'd4);
            chk("wait_pc", pc, 32'h0000_0104);
        end
        #2 reset_n = 1'b0;
        #1 chk("midfetch_rst_pc", pc, 32'h0040_0000);
        chk("midfetch_rst_instret", instret, 32'd0);
        chk("midfetch_rst_strobes", {29'd0, fetch_req, valid, mis}, 32'd0);

        ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wait_exec();
        drive(1'b1, 1'b0, 32'd2, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("trap2_mis", {31'd0, mis}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("trap_rst_pc", pc, 32'h0040_0000);
        chk("trap_rst_strobes", {29'd0, fetch_req, valid, mis}, 32'd0);
        chk("trap_rst_instret", instret, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0040_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0040_0100, PC value loaded on misaligned-target trap.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Branch_Flag_i  input  1  taken indication from Branch_Control; JAL/JALR arrive already forced to 1.
REQ-006 SHALL have port Jalr_i  input  1  selects register-relative target.
REQ-007 SHALL have port Imm_i  input  32  sign-extended immediate.
REQ-008 SHALL have port Rs1_i  input  32  rs1 read data.
REQ-009 SHALL have port Stall_i  input  1  holds the current instruction in execute.
REQ-010 SHALL have port Imem_Ready_i  input  1  instruction memory has returned the word for PC_o.
REQ-011 SHALL have port PC_o  output  32  current PC.
REQ-012 SHALL have port PC_Plus4_o  output  32  PC_o+4, combinational, link value.
REQ-013 SHALL have port Fetch_Req_o  output  1  fetch request to instruction memory.
REQ-014 SHALL have port Instr_Valid_o  output  1  the fetched instruction is being executed this cycle.
REQ-015 SHALL have port Misalign_o  output  1  trap pulse for a misaligned taken target.
REQ-016 SHALL have port Instret_o  output  32  retired-instruction counter.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, EXEC, TRAP.
REQ-018 BOOT SHALL last exactly one cycle, with all strobes low, then go to FETCH.
REQ-019 FETCH SHALL drive Fetch_Req_o=1 and stay in FETCH until Imem_Ready_i=1, then go to EXEC on the next edge.
REQ-020 EXEC SHALL drive Instr_Valid_o=1; while Stall_i=1 it SHALL stay in EXEC with PC_o and Instret_o unchanged.
REQ-021 In EXEC with Stall_i=0, next PC SHALL be: PC_o+Imm_i if Branch_Flag_i=1 and Jalr_i=0; (Rs1_i+Imm_i) with bit0 cleared if Branch_Flag_i=1 and Jalr_i=1; otherwise PC_o+4.
REQ-022 All additions SHALL be 32-bit modulo 2^32; wrap-around (e.g. 32'hFFFF_FFFC+4 -> 0) is legal.
REQ-023 Branch_Flag_i, Jalr_i, Imm_i and Rs1_i SHALL be ignored outside EXEC and whenever Stall_i=1.
REQ-024 A taken target with bit1=1 SHALL leave PC_o unchanged, leave Instret_o unchanged and go to TRAP.
REQ-025 Fall-through PC_o+4 SHALL never trap.
REQ-026 TRAP SHALL last one cycle with Misalign_o=1, SHALL load PC_o<=TRAP_VECTOR at its end, then go to FETCH.
REQ-027 A non-trapping EXEC exit SHALL load the next PC, increment Instret_o by 1 (wrapping), and go to FETCH.
REQ-028 Fetch_Req_o, Instr_Valid_o and Misalign_o SHALL be mutually exclusive and decoded from the state only.
REQ-029 Imem_Ready_i outside FETCH SHALL have no effect.

Reset
REQ-030 On reset=0, asynchronously: PC_o=RESET_VECTOR, state=BOOT, Instret_o=0, Fetch_Req_o=Instr_Valid_o=Misalign_o=0.
REQ-031 Reset asserted mid-FETCH, mid-stall or in TRAP SHALL abandon the operation with no partial PC or counter update.
REQ-032 After reset deassertion, the first Fetch_Req_o SHALL appear in the second cycle (BOOT, then FETCH).

Structure
REQ-033 A shared package pc_seq_pkg SHALL hold the state encoding and the RESET_VECTOR/TRAP_VECTOR defaults.
REQ-034 Next-PC and misalignment computation SHALL be one combinational sub-module, next_pc_calc.

Verification
REQ-035 Reset, then Imem_Ready_i=1 every cycle with no branches -> PC_o 0x00400000, 0x00400004, 0x00400008 at successive EXEC; Instret_o=1,2,3.
REQ-036 PC_o=0x00400010, Branch_Flag_i=1, Jalr_i=0, Imm_i=0xFFFFFFF8 -> next PC_o=0x00400008.
REQ-037 Branch_Flag_i=1, Jalr_i=1, Rs1_i=0x00400021, Imm_i=4 -> PC_o=0x00400024 (bit0 cleared), no trap.
REQ-038 Branch_Flag_i=1, Jalr_i=0, Imm_i=6 -> Misalign_o=1 for one cycle, then PC_o=0x00400100, Instret_o unchanged.
REQ-039 Stall_i=1 for 3 cycles in EXEC with Branch_Flag_i toggling -> PC_o and Instret_o frozen; release with Branch_Flag_i=0 -> PC_o+4.
REQ-040 Imem_Ready_i held 0 for 5 cycles, then reset pulsed -> Fetch_Req_o held through the wait; reset -> PC_o=0x00400000, BOOT, Instret_o=0.
